// File: rtl/fifo_pkg.sv
// Shared width helpers and read-mode constants for the flagged synchronous FIFO.
package fifo_pkg;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle shared by the FIFO and whoever drives it.
interface fifo_interface
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic             w_en;
  logic             r_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             w_en,
  input  logic [PW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [PW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, standard/FWFT read, threshold flags and error pulses.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FWFT      = MODE_STD,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_interface.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  localparam logic [PW-1:0] PtrLast  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AeCnt    = CW'(AE_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be at least 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be below DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             full, empty;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] rd_data;

  // Flags compare the registered count only, so they track count in the same cycle.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
  assign wr_ok = bus.w_en && (!full || bus.r_en);
  assign rd_ok = bus.r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= bus.w_en && full && !bus.r_en;
      underflow_q <= bus.r_en && empty;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk    (clk),
    .w_en   (wr_ok),
    .w_addr (wr_ptr_q),
    .w_data (bus.data_in),
    .r_addr (rd_ptr_q),
    .r_data (rd_data)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head entry is presented combinationally; forced to zero while empty.
    assign bus.data_out = empty ? '0 : rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= rd_data;
      end
    end

    assign bus.data_out = dout_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.almost_empty = (count_q <= AeCnt);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: standard, FWFT and non-power-of-2 instances.
module tb_sync_fifo_flags;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  logic [7:0] q_s [$];
  logic [7:0] q_n [$];
  logic [7:0] exp_b;
  logic [7:0] last_s;

  fifo_interface #(.DEPTH(8), .WIDTH(8)) if_s ();
  fifo_interface #(.DEPTH(8), .WIDTH(8)) if_f ();
  fifo_interface #(.DEPTH(5), .WIDTH(8)) if_n ();

  sync_fifo_flags #(
    .DEPTH(8), .WIDTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  sync_fifo_flags #(
    .DEPTH(8), .WIDTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_f)
  );

  sync_fifo_flags #(
    .DEPTH(5), .WIDTH(8), .FWFT(0), .AF_THRESH(3), .AE_THRESH(2)
  ) u_np (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_s(input logic w, input logic r, input logic [7:0] d);
    if_s.w_en = w; if_s.r_en = r; if_s.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic step_f(input logic w, input logic r, input logic [7:0] d);
    if_f.w_en = w; if_f.r_en = r; if_f.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic step_n(input logic w, input logic r, input logic [7:0] d);
    if_n.w_en = w; if_n.r_en = r; if_n.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) step_s(1'b1, 1'b0, 8'(8'h01 + i));
    step_s(1'b0, 1'b1, 8'h00);
    vectors++;
    if (if_s.data_out !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_pre_dout: got %h expected %h", if_s.data_out, 8'h01);
    end
    step_s(1'b1, 1'b0, 8'h06);
    vectors++;
    if (if_s.count !== 4'd5) begin
      miscompares++;
      $display("FAIL reset_pre_count: got %0d expected 5", if_s.count);
    end
    // Write in flight when reset drops mid-cycle.
    if_s.w_en = 1'b1; if_s.data_in = 8'h07;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (if_s.count !== 4'd0 || if_s.empty !== 1'b1 || if_s.almost_empty !== 1'b1 ||
        if_s.full !== 1'b0 || if_s.almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_flags: count=%0d empty=%b ae=%b full=%b af=%b expected 0 1 1 0 0",
               if_s.count, if_s.empty, if_s.almost_empty, if_s.full, if_s.almost_full);
    end
    vectors++;
    if (if_s.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async_dout: got %h expected 00", if_s.data_out);
    end
    @(posedge clk); #1;
    vectors++;
    if (if_s.count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_held_count: got %0d expected 0", if_s.count);
    end
    if_s.w_en = 1'b0;
    #2 rst_n = 1'b1;
    q_s.delete();
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 8; i++) begin
      step_s(1'b1, 1'b0, 8'(8'h10 + i));
      q_s.push_back(8'(8'h10 + i));
      vectors++;
      if (if_s.count !== 4'(i + 1) || if_s.almost_full !== (i + 1 >= 6) ||
          if_s.full !== (i + 1 == 8)) begin
        miscompares++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b expected %0d %b %b", i, if_s.count,
                 if_s.almost_full, if_s.full, i + 1, (i + 1 >= 6), (i + 1 == 8));
      end
    end
    step_s(1'b1, 1'b0, 8'hEE);
    vectors++;
    if (if_s.overflow !== 1'b1 || if_s.count !== 4'd8) begin
      miscompares++;
      $display("FAIL overflow_pulse: ovf=%b count=%0d expected 1 8", if_s.overflow, if_s.count);
    end
    step_s(1'b0, 1'b0, 8'h00);
    vectors++;
    if (if_s.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %b expected 0", if_s.overflow);
    end
    for (int i = 0; i < 8; i++) begin
      step_s(1'b0, 1'b1, 8'h00);
      exp_b = q_s.pop_front();
      last_s = exp_b;
      vectors++;
      if (if_s.data_out !== exp_b || if_s.count !== 4'(7 - i) || if_s.empty !== (i == 7)) begin
        miscompares++;
        $display("FAIL drain_%0d: dout=%h count=%0d empty=%b expected %h %0d %b", i,
                 if_s.data_out, if_s.count, if_s.empty, exp_b, 7 - i, (i == 7));
      end
    end
  endtask

  task automatic test_underflow;
    step_s(1'b0, 1'b1, 8'h00);
    vectors++;
    if (if_s.underflow !== 1'b1 || if_s.count !== 4'd0 || if_s.data_out !== last_s) begin
      miscompares++;
      $display("FAIL underflow_pulse: unf=%b count=%0d dout=%h expected 1 0 %h",
               if_s.underflow, if_s.count, if_s.data_out, last_s);
    end
    step_s(1'b0, 1'b0, 8'h00);
    vectors++;
    if (if_s.underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear: got %b expected 0", if_s.underflow);
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 8; i++) begin
      step_s(1'b1, 1'b0, 8'(8'h20 + i));
      q_s.push_back(8'(8'h20 + i));
    end
    for (int i = 0; i < 4; i++) begin
      step_s(1'b1, 1'b1, 8'(8'h30 + i));
      q_s.push_back(8'(8'h30 + i));
      exp_b = q_s.pop_front();
      vectors++;
      if (if_s.count !== 4'd8 || if_s.data_out !== exp_b || if_s.overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL full_rw_%0d: count=%0d dout=%h ovf=%b expected 8 %h 0", i, if_s.count,
                 if_s.data_out, if_s.overflow, exp_b);
      end
    end
    while (q_s.size() > 0) begin
      step_s(1'b0, 1'b1, 8'h00);
      exp_b = q_s.pop_front();
      vectors++;
      if (if_s.data_out !== exp_b) begin
        miscompares++;
        $display("FAIL full_rw_drain: got %h expected %h", if_s.data_out, exp_b);
      end
    end
    step_s(1'b1, 1'b1, 8'h55);
    q_s.push_back(8'h55);
    vectors++;
    if (if_s.count !== 4'd1 || if_s.underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_rw: count=%0d unf=%b expected 1 1", if_s.count, if_s.underflow);
    end
    step_s(1'b0, 1'b1, 8'h00);
    exp_b = q_s.pop_front();
    vectors++;
    if (if_s.data_out !== exp_b || if_s.count !== 4'd0) begin
      miscompares++;
      $display("FAIL empty_rw_pop: dout=%h count=%0d expected %h 0", if_s.data_out, if_s.count,
               exp_b);
    end
    step_s(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fwft;
    vectors++;
    if (if_f.data_out !== 8'h00 || if_f.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_idle: dout=%h empty=%b expected 00 1", if_f.data_out, if_f.empty);
    end
    step_f(1'b1, 1'b0, 8'hA5);
    vectors++;
    if (if_f.data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL fwft_first: got %h expected a5", if_f.data_out);
    end
    step_f(1'b1, 1'b0, 8'h5A);
    vectors++;
    if (if_f.data_out !== 8'hA5 || if_f.count !== 4'd2) begin
      miscompares++;
      $display("FAIL fwft_hold: dout=%h count=%0d expected a5 2", if_f.data_out, if_f.count);
    end
    step_f(1'b0, 1'b1, 8'h00);
    vectors++;
    if (if_f.data_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL fwft_pop1: got %h expected 5a", if_f.data_out);
    end
    step_f(1'b0, 1'b1, 8'h00);
    vectors++;
    if (if_f.data_out !== 8'h00 || if_f.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_pop2: dout=%h empty=%b expected 00 1", if_f.data_out, if_f.empty);
    end
    step_f(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_nonpow2;
    for (int i = 0; i < 5; i++) begin
      step_n(1'b1, 1'b0, 8'(8'h40 + i));
      q_n.push_back(8'(8'h40 + i));
      vectors++;
      if (if_n.count !== 3'(i + 1) || if_n.full !== (i == 4)) begin
        miscompares++;
        $display("FAIL np_fill_%0d: count=%0d full=%b expected %0d %b", i, if_n.count,
                 if_n.full, i + 1, (i == 4));
      end
    end
    for (int i = 0; i < 13; i++) begin
      step_n(1'b1, 1'b1, 8'(8'h80 + i));
      q_n.push_back(8'(8'h80 + i));
      exp_b = q_n.pop_front();
      vectors++;
      if (if_n.data_out !== exp_b || if_n.count !== 3'd5 || if_n.full !== 1'b1) begin
        miscompares++;
        $display("FAIL np_pair_%0d: dout=%h count=%0d full=%b expected %h 5 1", i,
                 if_n.data_out, if_n.count, if_n.full, exp_b);
      end
    end
    while (q_n.size() > 0) begin
      step_n(1'b0, 1'b1, 8'h00);
      exp_b = q_n.pop_front();
      vectors++;
      if (if_n.data_out !== exp_b || if_n.count !== 3'(q_n.size())) begin
        miscompares++;
        $display("FAIL np_drain: dout=%h count=%0d expected %h %0d", if_n.data_out,
                 if_n.count, exp_b, q_n.size());
      end
    end
    vectors++;
    if (if_n.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL np_empty: got %b expected 1", if_n.empty);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    last_s = 8'h00;
    rst_n = 1'b0;
    if_s.w_en = 1'b0; if_s.r_en = 1'b0; if_s.data_in = 8'h00;
    if_f.w_en = 1'b0; if_f.r_en = 1'b0; if_f.data_in = 8'h00;
    if_n.w_en = 1'b0; if_n.r_en = 1'b0; if_n.data_in = 8'h00;
    #12 rst_n = 1'b1;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_simultaneous();
    test_fwft();
    test_nonpow2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's synchronous_fifo, single clock domain. Adds:
- arbitrary (non-power-of-2) DEPTH
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost_full/almost_empty thresholds
- occupancy count
- overflow/underflow error pulses

Drop-in for synchronous_fifo: the base ports keep the same names and semantics, and the block drives the existing fifo_interface plus the added signals.

Parameters:
- DEPTH, 8, number of entries; legal range is 2 or more, and any integer is allowed.
- WIDTH, 8, data width in bits.
- FWFT, 0, read mode: 0 = standard with 1-cycle read latency; 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- w_en  input  1  write request.
- r_en  input  1  read request (pop).
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  one-cycle pulse for a rejected write.
- underflow  output  1  one-cycle pulse for a rejected read.

Behaviour:
- Reset values (rst_n low, applied asynchronously):
  - wr_ptr, rd_ptr, count, data_out, overflow and underflow are all 0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0).
  - Memory contents are not cleared.
- Accept rules, evaluated at each rising edge:
  - wr_ok = w_en && (!full || r_en)
  - rd_ok = r_en && !empty
- Full with w_en and r_en: both accepted; count unchanged (stays DEPTH).
- Empty with w_en and r_en: write accepted, read rejected, underflow pulses; count becomes 1.
- Pointers increment on wr_ok/rd_ok and wrap explicitly from DEPTH-1 to 0. Do not rely on power-of-2 rollover.
- Count update: count_next = count + wr_ok - rd_ok.
- Status flags: full, empty, almost_full and almost_empty are pure compares on the registered count, so they are valid in the same cycle count updates.
- Error pulses:
  - overflow is registered: asserts for exactly one cycle after an edge with w_en && full && !r_en.
  - underflow is registered: asserts for exactly one cycle after an edge with r_en && empty.
  - Neither pulse changes state.
- Standard mode (FWFT=0):
  - On an edge with rd_ok, data_out loads mem[rd_ptr] (1-cycle latency).
  - Otherwise data_out holds its previous value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever !empty, else 0.
  - The first word written to an empty FIFO is visible the cycle after its write edge.
  - rd_ok pops it, and the next word appears the following cycle.
- Write/read same address: a write and a read of the same entry on one edge cannot occur while count is 0, because the read is rejected. Memory is write-first for FWFT visibility only.
- Reset asserted mid-traffic: state clears immediately; any in-flight write is lost.
- Elaboration checks: assertion errors if DEPTH<2, AF_THRESH>DEPTH, or AE_THRESH>=DEPTH.

Decomposition:
- Package fifo_pkg:
  - function cnt_w(depth) returning $clog2(depth+1)
  - function ptr_w(depth) returning $clog2(depth), minimum 1
  - localparams MODE_STD=0 and MODE_FWFT=1
- One sub-module, fifo_mem:
  - simple dual-port register array, DEPTH x WIDTH
  - synchronous write, asynchronous read
  - no reset
- Top level holds pointers, count, flag compares, error pulses and the mode-dependent data_out path.

Test Plan:
All scenarios use DEPTH=8, WIDTH=8, AF_THRESH=6, AE_THRESH=2 unless noted.
- Reset: assert rst_n=0 mid-burst with count=5 → count=0, empty=1, almost_empty=1, full=0, data_out=0 immediately (asynchronous, no clock edge needed).
- Fill/drain (FWFT=0):
  - write 0x10..0x17 → almost_full rises when count=6, full at count=8.
  - 9th write → overflow pulses 1 cycle, count stays 8.
  - 8 reads → data_out 0x10..0x17 each one cycle after its r_en edge; empty at count=0.
- Underflow: r_en on empty → underflow pulses 1 cycle; data_out, count and pointers unchanged.
- Simultaneous R/W:
  - at full, w_en=r_en=1 for 4 cycles → count stays 8, order preserved.
  - at empty, w_en=r_en=1 → count=1, underflow=1.
- FWFT=1: write 0xA5 into empty → data_out=0xA5 next cycle with no r_en; pop → data_out shows the next word or 0 if empty.
- Non-power-of-2 (DEPTH=5): 13 write/read pairs → pointers wrap 4→0 correctly, data order intact, full at count=5.
